// File: rtl/axis_input_scheduler_pkg.sv
// Shared definitions for the AXI-Stream input scheduler.
// Holds the scheduler state encoding and the default stream and
// iteration-count widths. The top module and the skid buffer both use them.
package axis_input_scheduler_pkg;

    localparam int DEF_WIDTH     = 64;
    localparam int DEF_ITR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WEIGHTS = 2'd1,
        PIXELS  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer.
// Ports:
//   aclk, areset          : clock, synchronous active-high reset
//   s_valid/s_ready/...   : upstream beat (data, keep, last)
//   m_valid/m_ready/...   : downstream beat, registered (1-cycle latency)
//   busy                  : 1 while either entry holds a beat
// Handshake: a beat moves when valid && ready are both 1 at a rising edge.
// Valid never depends on ready. Once valid is raised, it and the payload are
// held until the beat is accepted.
// s_ready is a flop output (not skid full), so m_ready never reaches s_ready
// combinationally.
module axis_skid_buffer
    import axis_input_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    input  logic [WIDTH/8-1:0] s_keep,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [WIDTH/8-1:0] m_keep,
    output logic               m_last,
    output logic               busy
);

    localparam int BW = WIDTH + WIDTH/8 + 1;

    logic [BW-1:0] out_q, out_d, skid_q, skid_d;
    logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic          accept;

    assign s_ready = !skid_vld_q;
    assign accept  = s_valid && !skid_vld_q;

    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || m_ready) begin
            // Output slot frees up this cycle. Refill it from the skid entry
            // first. Otherwise fill it from the input. A full skid entry
            // implies no accept this cycle.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_d = {s_data, s_keep, s_last};
                end
            end
        end else if (accept) begin
            // Output is stalled. Park the beat that was accepted under the
            // previous cycle's ready.
            skid_d     = {s_data, s_keep, s_last};
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Payload registers need no reset because they are qualified by the valid flags.
    always_ff @(posedge aclk) begin
        out_q  <= out_d;
        skid_q <= skid_d;
    end

    assign m_valid = out_vld_q;
    assign {m_data, m_keep, m_last} = out_q;
    assign busy    = out_vld_q || skid_vld_q;

endmodule

// File: rtl/axis_input_scheduler.sv
// Splits one DMA input stream into weight and pixel streams, one layer at a time.
// A layer is cfg_itr pairs of packets: a weights packet, then a pixels packet.
// Ports:
//   aclk, areset                 : clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_itr  : layer start and its iteration count
//   s_axis_*                     : shared input stream
//   m_axis_weights_*             : weight rotator stream (via skid buffer)
//   m_axis_pixels_*              : pixel pipe stream (via skid buffer)
//   busy, done, itr_count        : status. done is a single-cycle pulse.
//   dbg_state                    : current scheduler state
// Handshake: a beat or config moves when valid && ready are both 1 at a
// rising edge.
module axis_input_scheduler
    import axis_input_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ITR_WIDTH = DEF_ITR_WIDTH
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ITR_WIDTH-1:0] cfg_itr,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic [WIDTH/8-1:0]   s_axis_tkeep,
    output logic                 m_axis_weights_tvalid,
    input  logic                 m_axis_weights_tready,
    output logic                 m_axis_weights_tlast,
    output logic [WIDTH-1:0]     m_axis_weights_tdata,
    output logic [WIDTH/8-1:0]   m_axis_weights_tkeep,
    output logic                 m_axis_pixels_tvalid,
    input  logic                 m_axis_pixels_tready,
    output logic                 m_axis_pixels_tlast,
    output logic [WIDTH-1:0]     m_axis_pixels_tdata,
    output logic [WIDTH/8-1:0]   m_axis_pixels_tkeep,
    output logic                 busy,
    output logic                 done,
    output logic [ITR_WIDTH-1:0] itr_count,
    output sched_state_e         dbg_state
);

    sched_state_e         state_q, state_d;
    logic [ITR_WIDTH-1:0] itr_q, itr_d, cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 w_s_ready, p_s_ready, w_busy, p_busy;
    logic                 w_s_valid, p_s_valid, beat_acc, cfg_fire;

    assign cfg_ready     = (state_q == IDLE) && !areset;
    assign cfg_fire      = cfg_valid && cfg_ready;
    assign w_s_valid     = s_axis_tvalid && (state_q == WEIGHTS);
    assign p_s_valid     = s_axis_tvalid && (state_q == PIXELS);
    // Only the selected buffer's ready matters. Stalls on the other output never reach the input.
    assign s_axis_tready = !areset && (((state_q == WEIGHTS) && w_s_ready) ||
                                       ((state_q == PIXELS)  && p_s_ready));
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        itr_d   = itr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    if (cfg_itr != '0) begin
                        itr_d   = cfg_itr;
                        cnt_d   = '0;
                        state_d = WEIGHTS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WEIGHTS: begin
                if (beat_acc && s_axis_tlast) begin
                    state_d = PIXELS;
                end
            end
            PIXELS: begin
                if (beat_acc && s_axis_tlast) begin
                    if (cnt_q == itr_q - ITR_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + ITR_WIDTH'(1);
                        state_d = WEIGHTS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            itr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            itr_q   <= itr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    axis_skid_buffer #(.WIDTH(WIDTH)) u_weights_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_valid (w_s_valid),
        .s_ready (w_s_ready),
        .s_data  (s_axis_tdata),
        .s_keep  (s_axis_tkeep),
        .s_last  (s_axis_tlast),
        .m_valid (m_axis_weights_tvalid),
        .m_ready (m_axis_weights_tready),
        .m_data  (m_axis_weights_tdata),
        .m_keep  (m_axis_weights_tkeep),
        .m_last  (m_axis_weights_tlast),
        .busy    (w_busy)
    );

    axis_skid_buffer #(.WIDTH(WIDTH)) u_pixels_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_valid (p_s_valid),
        .s_ready (p_s_ready),
        .s_data  (s_axis_tdata),
        .s_keep  (s_axis_tkeep),
        .s_last  (s_axis_tlast),
        .m_valid (m_axis_pixels_tvalid),
        .m_ready (m_axis_pixels_tready),
        .m_data  (m_axis_pixels_tdata),
        .m_keep  (m_axis_pixels_tkeep),
        .m_last  (m_axis_pixels_tlast),
        .busy    (p_busy)
    );

    assign busy      = !areset && ((state_q != IDLE) || w_busy || p_busy);
    assign done      = done_q;
    assign itr_count = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axis_input_scheduler.sv
module tb_axis_input_scheduler;
    import axis_input_scheduler_pkg::*;

    localparam int WIDTH     = 64;
    localparam int ITR_WIDTH = 16;
    localparam int KW        = WIDTH / 8;
    localparam int BW        = WIDTH + KW + 1;

    logic                 aclk, areset;
    logic                 cfg_valid, cfg_ready;
    logic [ITR_WIDTH-1:0] cfg_itr;
    logic                 s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [WIDTH-1:0]     s_axis_tdata;
    logic [KW-1:0]        s_axis_tkeep;
    logic                 m_axis_weights_tvalid, m_axis_weights_tready, m_axis_weights_tlast;
    logic [WIDTH-1:0]     m_axis_weights_tdata;
    logic [KW-1:0]        m_axis_weights_tkeep;
    logic                 m_axis_pixels_tvalid, m_axis_pixels_tready, m_axis_pixels_tlast;
    logic [WIDTH-1:0]     m_axis_pixels_tdata;
    logic [KW-1:0]        m_axis_pixels_tkeep;
    logic                 busy, done;
    logic [ITR_WIDTH-1:0] itr_count;
    sched_state_e         dbg_state;

    logic [BW-1:0] exp_w_q[$];
    logic [BW-1:0] exp_p_q[$];
    int            compared, mismatched;
    int            cyc, done_cnt, bad_stall;
    logic          last_acc, last_cfg, bp_en;

    axis_input_scheduler #(.WIDTH(WIDTH), .ITR_WIDTH(ITR_WIDTH)) dut (
        .aclk                  (aclk),
        .areset                (areset),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_itr               (cfg_itr),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tready         (s_axis_tready),
        .s_axis_tlast          (s_axis_tlast),
        .s_axis_tdata          (s_axis_tdata),
        .s_axis_tkeep          (s_axis_tkeep),
        .m_axis_weights_tvalid (m_axis_weights_tvalid),
        .m_axis_weights_tready (m_axis_weights_tready),
        .m_axis_weights_tlast  (m_axis_weights_tlast),
        .m_axis_weights_tdata  (m_axis_weights_tdata),
        .m_axis_weights_tkeep  (m_axis_weights_tkeep),
        .m_axis_pixels_tvalid  (m_axis_pixels_tvalid),
        .m_axis_pixels_tready  (m_axis_pixels_tready),
        .m_axis_pixels_tlast   (m_axis_pixels_tlast),
        .m_axis_pixels_tdata   (m_axis_pixels_tdata),
        .m_axis_pixels_tkeep   (m_axis_pixels_tkeep),
        .busy                  (busy),
        .done                  (done),
        .itr_count             (itr_count),
        .dbg_state             (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output monitor / scoreboard pop, run at the falling edge.
    task automatic sample();
        logic [BW-1:0] got, e;
        last_acc = s_axis_tvalid && s_axis_tready;
        last_cfg = cfg_valid && cfg_ready;
        if (!areset) begin
            if (done) done_cnt++;
            if (bp_en && s_axis_tvalid && !s_axis_tready && !m_axis_pixels_tvalid) bad_stall++;
            if (m_axis_weights_tvalid && m_axis_weights_tready) begin
                got = {m_axis_weights_tdata, m_axis_weights_tkeep, m_axis_weights_tlast};
                compared++;
                if (exp_w_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL weights_unexpected got=%h expected=none", got);
                end else begin
                    e = exp_w_q.pop_front();
                    if (got !== e) begin
                        mismatched++;
                        $display("FAIL weights_beat got=%h expected=%h", got, e);
                    end
                end
            end
            if (m_axis_pixels_tvalid && m_axis_pixels_tready) begin
                got = {m_axis_pixels_tdata, m_axis_pixels_tkeep, m_axis_pixels_tlast};
                compared++;
                if (exp_p_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL pixels_unexpected got=%h expected=none", got);
                end else begin
                    e = exp_p_q.pop_front();
                    if (got !== e) begin
                        mismatched++;
                        $display("FAIL pixels_beat got=%h expected=%h", got, e);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        cyc++;
        #1;
        if (bp_en) m_axis_pixels_tready = 1'($urandom_range(0, 1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input bit pix, input bit last, output int acc_cyc);
        logic [WIDTH-1:0] d;
        logic [KW-1:0]    k;
        int               n;
        d = {$urandom, $urandom};
        k = KW'($urandom_range(0, 255));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        acc_cyc = cyc;
        compared++;
        if (!last_acc) begin
            mismatched++;
            $display("FAIL beat_accept_timeout got=not_accepted expected=accepted");
        end else if (pix) begin
            exp_p_q.push_back({d, k, last});
        end else begin
            exp_w_q.push_back({d, k, last});
        end
    endtask

    task automatic send_packet(input bit pix, input int nbeats, output int first_cyc, output int last_cyc);
        int c;
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < nbeats; i++) begin
            send_beat(pix, (i == nbeats - 1), c);
            if (i == 0) first_cyc = c;
            last_cyc = c;
        end
    endtask

    task automatic do_cfg(input logic [ITR_WIDTH-1:0] itr);
        int n;
        cfg_valid = 1'b1;
        cfg_itr   = itr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_cfg && n < 50);
        cfg_valid = 1'b0;
        compared++;
        if (!last_cfg) begin
            mismatched++;
            $display("FAIL cfg_timeout got=no_handshake expected=handshake");
        end
    endtask

    task automatic drain();
        int n;
        s_axis_tvalid         = 1'b0;
        bp_en                 = 1'b0;
        m_axis_weights_tready = 1'b1;
        m_axis_pixels_tready  = 1'b1;
        n = 0;
        while ((busy || exp_w_q.size() != 0 || exp_p_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        tick();
        compared++;
        if (busy !== 1'b0 || exp_w_q.size() != 0 || exp_p_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got=busy%0b/w%0d/p%0d expected=busy0/w0/p0", busy, exp_w_q.size(), exp_p_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        compared++;
        if (cfg_ready !== 1'b0 || s_axis_tready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_readys got=cfg%b/s%b expected=0/0", cfg_ready, s_axis_tready);
        end
        compared++;
        if (m_axis_weights_tvalid !== 1'b0 || m_axis_pixels_tvalid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs got=w%b/p%b/done%b/busy%b expected=0/0/0/0",
                     m_axis_weights_tvalid, m_axis_pixels_tvalid, done, busy);
        end
        areset = 1'b0;
        #1;
        compared++;
        if (cfg_ready !== 1'b1 || dbg_state !== IDLE || itr_count !== '0) begin
            mismatched++;
            $display("FAIL reset_release got=cfg%b/st%0d/itr%0d expected=1/0/0", cfg_ready, dbg_state, itr_count);
        end
    endtask

    task automatic test_basic();
        int d0, f, l;
        d0 = done_cnt;
        do_cfg(ITR_WIDTH'(2));
        for (int it = 0; it < 2; it++) begin
            compared++;
            if (itr_count !== ITR_WIDTH'(it) || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL basic_itr_count got=%0d/busy%b expected=%0d/1", itr_count, busy, it);
            end
            send_packet(1'b0, 4, f, l);
            send_packet(1'b1, 3, f, l);
        end
        compared++;
        if (done !== 1'b1 || done_cnt != d0) begin
            mismatched++;
            $display("FAIL basic_done_timing got=done%b/early%0d expected=1/0", done, done_cnt - d0);
        end
        drain();
        compared++;
        if (done_cnt - d0 != 1 || dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL basic_done_count got=%0d/st%0d expected=1/0", done_cnt - d0, dbg_state);
        end
    endtask

    task automatic test_zero_itr();
        int d0, acc;
        d0 = done_cnt;
        do_cfg('0);
        compared++;
        if (done !== 1'b1 || dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL zero_done got=done%b/st%0d expected=1/0", done, dbg_state);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) acc++;
        end
        s_axis_tvalid = 1'b0;
        compared++;
        if (acc != 0 || done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL zero_holdoff got=acc%0d/done%0d expected=0/1", acc, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        do_cfg(ITR_WIDTH'(1));
        send_packet(1'b0, 4, f, l);
        m_axis_weights_tready = 1'b0;
        bad_stall = 0;
        bp_en     = 1'b1;
        send_packet(1'b1, 8, f, l);
        compared++;
        if (bad_stall != 0 || m_axis_weights_tvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_stall got=stalls%0d/wvalid%b expected=0/1", bad_stall, m_axis_weights_tvalid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int f, lw, c1, c2;
        logic [BW-1:0] e;
        do_cfg(ITR_WIDTH'(1));
        send_packet(1'b0, 2, f, lw);
        send_beat(1'b1, 1'b0, c1);
        e = exp_p_q[$];
        compared++;
        if (c1 != lw + 1) begin
            mismatched++;
            $display("FAIL b2b_bubble got=cycle%0d expected=cycle%0d", c1, lw + 1);
        end
        compared++;
        if (m_axis_pixels_tvalid !== 1'b1 || {m_axis_pixels_tdata, m_axis_pixels_tkeep, m_axis_pixels_tlast} !== e) begin
            mismatched++;
            $display("FAIL b2b_latency got=v%b/%h expected=v1/%h", m_axis_pixels_tvalid,
                     {m_axis_pixels_tdata, m_axis_pixels_tkeep, m_axis_pixels_tlast}, e);
        end
        send_beat(1'b1, 1'b1, c2);
        compared++;
        if (c2 != c1 + 1) begin
            mismatched++;
            $display("FAIL b2b_throughput got=cycle%0d expected=cycle%0d", c2, c1 + 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int f, l, c, d0;
        do_cfg(ITR_WIDTH'(3));
        send_packet(1'b0, 4, f, l);
        send_packet(1'b1, 3, f, l);
        m_axis_weights_tready = 1'b0;
        send_beat(1'b0, 1'b0, c);
        send_beat(1'b0, 1'b0, c);
        d0 = done_cnt;
        areset = 1'b1;
        tick();
        compared++;
        if (s_axis_tready !== 1'b0 || cfg_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_during got=s%b/cfg%b expected=0/0", s_axis_tready, cfg_ready);
        end
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_w_q.delete();
        exp_p_q.delete();
        #1;
        compared++;
        if (m_axis_weights_tvalid !== 1'b0 || m_axis_pixels_tvalid !== 1'b0 ||
            dbg_state !== IDLE || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_after got=w%b/p%b/st%0d/cfg%b/busy%b expected=0/0/0/1/0",
                     m_axis_weights_tvalid, m_axis_pixels_tvalid, dbg_state, cfg_ready, busy);
        end
        m_axis_weights_tready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        compared++;
        if (done_cnt != d0) begin
            mismatched++;
            $display("FAIL rstmid_done got=%0d expected=0", done_cnt - d0);
        end
    endtask

    task automatic test_single_beat();
        int d0, c, prev, gaps, badcnt;
        d0     = done_cnt;
        gaps   = 0;
        badcnt = 0;
        prev   = -1;
        do_cfg(ITR_WIDTH'(5));
        for (int i = 0; i < 5; i++) begin
            send_beat(1'b0, 1'b1, c);
            if (prev >= 0 && c != prev + 1) gaps++;
            prev = c;
            if (itr_count !== ITR_WIDTH'(i)) badcnt++;
            send_beat(1'b1, 1'b1, c);
            if (c != prev + 1) gaps++;
            prev = c;
        end
        compared++;
        if (gaps != 0 || badcnt != 0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL single_beat got=gaps%0d/itrbad%0d/done%b expected=0/0/1", gaps, badcnt, done);
        end
        drain();
        compared++;
        if (done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL single_done_count got=%0d expected=1", done_cnt - d0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        compared = 0; mismatched = 0; cyc = 0; done_cnt = 0; bad_stall = 0;
        last_acc = 1'b0; last_cfg = 1'b0; bp_en = 1'b0;
        areset = 1'b1; cfg_valid = 1'b0; cfg_itr = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        m_axis_weights_tready = 1'b1;
        m_axis_pixels_tready  = 1'b1;
        test_reset();
        test_basic();
        test_zero_itr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_single_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
